button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Conditions the raw Cmod S7 push-buttons before they reach the LED/heartbeat logic in top_level.
//  Per button: metastability synchronizer, counter-based debounce, one-cycle press/release pulses and a
//  long-press pulse. Its btn_level output replaces top_level's inline 3-flop shift registers (resetX/resetY),
//  and btn_long is available as a clean reset request for heartbeat_with_classes.
// PARAMETERS
//  N_BTN             2         number of independent button channels
//  SYNC_STAGES       3         synchronizer flops per channel (>=2)
//  DEBOUNCE_CYCLES   120000    consecutive stable samples required to accept a change (10 ms @ 12 MHz, >=1)
//  LONG_PRESS_CYCLES 12000000  cycles btn_level must stay high before btn_long fires (1 s @ 12 MHz, >=1)
// PORTS
//  clk          input   1      system clock
//  reset        input   1      synchronous, active-high reset
//  btn_raw      input   N_BTN  asynchronous raw button pins, active-high
//  btn_level    output  N_BTN  debounced button state, registered
//  btn_press    output  N_BTN  1-cycle pulse on debounced rising edge
//  btn_release  output  N_BTN  1-cycle pulse on debounced falling edge
//  btn_long     output  N_BTN  1-cycle pulse, once per press, when hold time reaches LONG_PRESS_CYCLES
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high. All state updates on posedge clk.
//  - Reset: sync flops 0, FSM RELEASED, counters 0, btn_level/press/release/long all 0 on the edge reset is sampled.
//  - Channels fully independent; no cross-channel priority or interaction.
//  - Per-channel FSM on synchronized sample s:
//    RELEASED     : s=1 -> PRESS_WAIT (deb_cnt=1). else stay.
//    PRESS_WAIT   : s=0 -> RELEASED, deb_cnt=0 (bounce rejected, no pulses).
//                   s=1 and deb_cnt==DEBOUNCE_CYCLES -> PRESSED; btn_level<=1, btn_press<=1, hold_cnt=0. else deb_cnt++.
//    PRESSED      : s=0 -> RELEASE_WAIT (deb_cnt=1). else stay.
//    RELEASE_WAIT : s=1 -> PRESSED, deb_cnt=0 (glitch rejected).
//                   s=0 and deb_cnt==DEBOUNCE_CYCLES -> RELEASED; btn_level<=0, btn_release<=1. else deb_cnt++.
//  - Latency: btn_raw held high from edge 0 -> btn_level and btn_press high after edge SYNC_STAGES+DEBOUNCE_CYCLES;
//    release symmetric. Pulses last exactly one cycle, coincident with the btn_level transition cycle.
//  - Hold counter: runs in PRESSED and RELEASE_WAIT, saturates at LONG_PRESS_CYCLES; btn_long pulses on the
//    cycle it reaches LONG_PRESS_CYCLES, never again until a new press; cleared on entry to PRESSED from PRESS_WAIT.
//  - btn_long and btn_release never assert in the same cycle for the same channel; if the release is accepted on the
//    cycle the hold count would reach the limit, release wins and btn_long is suppressed.
//  - Counter widths: $clog2(max+1) of their limit; no wrap-around permitted (compare with ==, saturate hold).
//  - DEBOUNCE_CYCLES=1: single stable sample accepts change (pure synchronizer + edge detect).
//  - Reset mid-operation: all channels return to RELEASED with no pulse; a button still held after reset
//    is re-detected as a fresh press after the full SYNC_STAGES+DEBOUNCE_CYCLES latency.
//  - Elaboration-time assertions: SYNC_STAGES>=2, DEBOUNCE_CYCLES>=1, LONG_PRESS_CYCLES>=1.
// STRUCTURE
//  - Package vecheck_btn_pkg: typedef enum logic[1:0] btn_state_t {RELEASED, PRESS_WAIT, PRESSED,
//    RELEASE_WAIT}; default cycle constants for the 12 MHz board clock.
//  - Sub-module button_channel: one synchronizer + FSM + counters for a single button; button_conditioner
//    is a generate loop of N_BTN instances plus output packing.
// TESTING (bench params: N_BTN=2, SYNC_STAGES=3, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16)
//  1 Clean press: btn_raw[0] 0->1 at edge 0, held -> btn_level[0]=1 and btn_press[0]=1 for one cycle after edge 7; ch1 stays 0.
//  2 Bounce reject: btn_raw[0] toggles 1,1,1,0 repeatedly (high runs of 3) -> btn_level[0] stays 0, no pulses.
//  3 Release glitch: while pressed, btn_raw[0]=0 for 2 cycles then 1 -> btn_level stays 1, no btn_release;
//    then 0 held -> btn_release pulse, btn_level=0 after 7 edges.
//  4 Long press: hold btn_raw[1]=1 for 40 cycles -> exactly one btn_long[1] pulse 16 cycles after btn_level[1] rise.
//  5 Simultaneous: both buttons pressed same edge -> identical press pulses on both channels same cycle.
//  6 Reset mid-press: assert reset 1 cycle while btn_level[0]=1 and raw held -> all outputs 0 next edge,
//    no release pulse, new btn_press 7 edges after reset deasserts.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared types and board-level default timing for the push-button conditioner.
package vecheck_btn_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Cmod S7 board clock and the matching default timings
    localparam int CLK_HZ                    = 12_000_000;
    localparam int DEFAULT_N_BTN             = 2;
    localparam int DEFAULT_SYNC_STAGES       = 3;
    localparam int DEFAULT_DEBOUNCE_CYCLES   = CLK_HZ / 100;
    localparam int DEFAULT_LONG_PRESS_CYCLES = CLK_HZ;

endpackage

// File: rtl/button_conditioner_if.sv
// Bundle of raw button pins and their conditioned outputs.
// master drives the raw pins and consumes the results; slave is the conditioner.
interface button_conditioner_if #(
    parameter int N_BTN = 2
);

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );

endinterface

// File: rtl/button_conditioner_channel.sv
// One button: synchronizer, debounce FSM, edge pulses and long-press detection.
module button_channel
    import vecheck_btn_pkg::*;
#(
    parameter int SYNC_STAGES       = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DW-1:0] DEB_ONE   = DW'(1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    localparam logic [1:0] S_RELEASED     = RELEASED;
    localparam logic [1:0] S_PRESS_WAIT   = PRESS_WAIT;
    localparam logic [1:0] S_PRESSED      = PRESSED;
    localparam logic [1:0] S_RELEASE_WAIT = RELEASE_WAIT;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_channel: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("button_channel: DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_PRESS_CYCLES < 1) begin : g_bad_long
        $error("button_channel: LONG_PRESS_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [1:0]             state;
    logic [DW-1:0]          deb_cnt;
    logic [HW-1:0]          hold_cnt;
    logic                   release_accept;
    logic                   hold_run;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the asynchronous pin through the synchronizer chain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // Release acceptance beats the long-press pulse; hold count stops once saturated
    always_comb begin
        release_accept = (state == S_RELEASE_WAIT) && !s && (deb_cnt == DEB_MAX);
        hold_run       = ((state == S_PRESSED) || (state == S_RELEASE_WAIT))
                         && !release_accept && (hold_cnt != HOLD_MAX);
    end

    // Debounce FSM with its counters and the registered one-cycle pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RELEASED;
            deb_cnt     <= '0;
            hold_cnt    <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;
            case (state)
                S_RELEASED: begin
                    if (s) begin
                        state   <= S_PRESS_WAIT;
                        deb_cnt <= DEB_ONE;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!s) begin
                        state   <= S_RELEASED;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_MAX) begin
                        state     <= S_PRESSED;
                        deb_cnt   <= '0;
                        hold_cnt  <= '0;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (!s) begin
                        state   <= S_RELEASE_WAIT;
                        deb_cnt <= DEB_ONE;
                    end
                end
                default: begin
                    if (s) begin
                        state   <= S_PRESSED;
                        deb_cnt <= '0;
                    end else if (release_accept) begin
                        state       <= S_RELEASED;
                        deb_cnt     <= '0;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
            endcase
            if (hold_run) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    btn_long <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Top: one independent button_channel per button, outputs packed onto the interface.
module button_conditioner
    import vecheck_btn_pkg::*;
#(
    parameter int N_BTN             = DEFAULT_N_BTN,
    parameter int SYNC_STAGES       = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input logic                 clk,
    input logic                 reset,
    button_conditioner_if.slave btn
);

    logic [N_BTN-1:0] level_w;
    logic [N_BTN-1:0] press_w;
    logic [N_BTN-1:0] release_w;
    logic [N_BTN-1:0] long_w;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_channel #(
            .SYNC_STAGES       (SYNC_STAGES),
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .btn_raw     (btn.btn_raw[i]),
            .btn_level   (level_w[i]),
            .btn_press   (press_w[i]),
            .btn_release (release_w[i]),
            .btn_long    (long_w[i])
        );
    end

    assign btn.btn_level   = level_w;
    assign btn.btn_press   = press_w;
    assign btn.btn_release = release_w;
    assign btn.btn_long    = long_w;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (SYNC=3, DEBOUNCE=4, LONG=16).
module tb_button_conditioner;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   press_tot[2]   = '{0, 0};
    int   release_tot[2] = '{0, 0};
    int   long_tot[2]    = '{0, 0};
    int   press_base[2];
    int   release_base[2];
    int   long_base[2];

    button_conditioner_if #(.N_BTN(2)) bif ();

    button_conditioner #(
        .N_BTN             (2),
        .SYNC_STAGES       (3),
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif.slave)
    );

    // 10-time-unit clock
    always #5 clk = ~clk;

    // Tally every pulse seen, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (bif.btn_press[i])   press_tot[i]++;
            if (bif.btn_release[i]) release_tot[i]++;
            if (bif.btn_long[i])    long_tot[i]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a raw pattern for n clock edges
    task automatic applyStimulus(input logic [1:0] raw, input int n);
        bif.btn_raw = raw;
        repeat (n) tick();
    endtask

    task automatic clearCounts();
        for (int i = 0; i < 2; i++) begin
            press_base[i]   = press_tot[i];
            release_base[i] = release_tot[i];
            long_base[i]    = long_tot[i];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        bif.btn_raw = 2'b00;
        reset = 1'b1;
        repeat (3) tick();
        checkOutput("rst_level",   32'(bif.btn_level),   32'h0);
        checkOutput("rst_press",   32'(bif.btn_press),   32'h0);
        checkOutput("rst_release", 32'(bif.btn_release), 32'h0);
        checkOutput("rst_long",    32'(bif.btn_long),    32'h0);
        reset = 1'b0;
        applyStimulus(2'b00, 5);

        // Clean press on ch0, then a short release glitch, then a release
        // timed so it is accepted on the edge the hold count would hit 16
        clearCounts();
        applyStimulus(2'b01, 7);
        checkOutput("t1_level_early", 32'(bif.btn_level), 32'h0);
        tick();
        checkOutput("t1_level", 32'(bif.btn_level), 32'h1);
        checkOutput("t1_press", 32'(bif.btn_press), 32'h1);
        tick();
        checkOutput("t1_press_gone", 32'(bif.btn_press), 32'h0);
        applyStimulus(2'b00, 2);
        applyStimulus(2'b01, 5);
        checkOutput("t3_glitch_level", 32'(bif.btn_level), 32'h1);
        checkOutput("t3_glitch_rel", 32'(release_tot[0] - release_base[0]), 32'd0);
        applyStimulus(2'b00, 7);
        checkOutput("t3_level_held", 32'(bif.btn_level), 32'h1);
        tick();
        checkOutput("t3_level_low", 32'(bif.btn_level), 32'h0);
        checkOutput("t3_release", 32'(bif.btn_release), 32'h1);
        checkOutput("t3_long_now", 32'(bif.btn_long), 32'h0);
        tick();
        checkOutput("t3_release_gone", 32'(bif.btn_release), 32'h0);
        applyStimulus(2'b00, 4);
        checkOutput("t1_press_cnt0", 32'(press_tot[0] - press_base[0]), 32'd1);
        checkOutput("t1_press_cnt1", 32'(press_tot[1] - press_base[1]), 32'd0);
        checkOutput("t3_rel_cnt0", 32'(release_tot[0] - release_base[0]), 32'd1);
        checkOutput("t3_long_suppressed", 32'(long_tot[0] - long_base[0]), 32'd0);

        // Bounce: high runs of three samples never satisfy the debounce
        clearCounts();
        for (int r = 0; r < 5; r++) begin
            applyStimulus(2'b01, 3);
            applyStimulus(2'b00, 1);
        end
        applyStimulus(2'b00, 10);
        checkOutput("t2_level", 32'(bif.btn_level), 32'h0);
        checkOutput("t2_press_cnt", 32'(press_tot[0] - press_base[0]), 32'd0);
        checkOutput("t2_rel_cnt", 32'(release_tot[0] - release_base[0]), 32'd0);

        // Long press on ch1: one pulse 16 cycles after the level rises
        clearCounts();
        applyStimulus(2'b10, 23);
        checkOutput("t4_level", 32'(bif.btn_level), 32'h2);
        checkOutput("t4_long_early", 32'(long_tot[1] - long_base[1]), 32'd0);
        tick();
        checkOutput("t4_long", 32'(bif.btn_long), 32'h2);
        applyStimulus(2'b10, 16);
        checkOutput("t4_long_cnt", 32'(long_tot[1] - long_base[1]), 32'd1);
        applyStimulus(2'b00, 10);
        checkOutput("t4_level_low", 32'(bif.btn_level), 32'h0);
        checkOutput("t4_rel_cnt", 32'(release_tot[1] - release_base[1]), 32'd1);
        checkOutput("t4_long_cnt_end", 32'(long_tot[1] - long_base[1]), 32'd1);

        // Simultaneous press on both channels
        clearCounts();
        applyStimulus(2'b11, 7);
        checkOutput("t5_press_early", 32'(bif.btn_press), 32'h0);
        tick();
        checkOutput("t5_press", 32'(bif.btn_press), 32'h3);
        checkOutput("t5_level", 32'(bif.btn_level), 32'h3);
        applyStimulus(2'b11, 2);

        // Reset while both are held: silent clear, then full re-detection
        reset = 1'b1;
        tick();
        checkOutput("t6_rst_level",   32'(bif.btn_level),   32'h0);
        checkOutput("t6_rst_press",   32'(bif.btn_press),   32'h0);
        checkOutput("t6_rst_release", 32'(bif.btn_release), 32'h0);
        checkOutput("t6_rst_long",    32'(bif.btn_long),    32'h0);
        reset = 1'b0;
        clearCounts();
        applyStimulus(2'b11, 7);
        checkOutput("t6_level_early", 32'(bif.btn_level), 32'h0);
        checkOutput("t6_no_release", 32'(release_tot[0] + release_tot[1] - release_base[0] - release_base[1]), 32'd0);
        tick();
        checkOutput("t6_press", 32'(bif.btn_press), 32'h3);
        checkOutput("t6_level", 32'(bif.btn_level), 32'h3);
        applyStimulus(2'b00, 10);
        checkOutput("t6_level_low", 32'(bif.btn_level), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
